// File: rtl/bmux_2_pkg.sv
// bmux_2_pkg: shared constants for the processor datapath.
//   DATA_W : native datapath width, used as the default operand width
//            of the datapath multiplexers.
package bmux_2_pkg;

  localparam int DATA_W = 16;

endpackage : bmux_2_pkg

// File: rtl/bmux_2.sv
// bmux_2: 2-to-1 bus multiplexer for datapath operand / writeback / PC
// source selection, with a registered copy of the result and select for
// pipeline-stage use.
//
// Ports:
//   clk    in   1      system clock, rising edge; drives only r_q / s_q
//   reset  in   1      asynchronous active-high reset; clears r_q / s_q only
//   s      in   1      select: 0 -> A, 1 -> B
//   A      in   WIDTH  data input 0
//   B      in   WIDTH  data input 1
//   r      out  WIDTH  combinational result, s ? B : A
//   r_q    out  WIDTH  registered copy of r
//   s_q    out  1      registered copy of s
module bmux_2
  import bmux_2_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_q,
  output logic             s_q
);

  // Plain ternary: an unknown select propagates as X rather than
  // defaulting to either input.
  assign r = s ? B : A;

  // Reset only touches the pipeline copy; r stays live during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      s_q <= 1'b0;
    end else begin
      r_q <= r;
      s_q <= s;
    end
  end

endmodule : bmux_2

// File: tb/tb_bmux_2.sv
// tb_bmux_2: directed bench for bmux_2 with a behavioural reference model
// and a per-cycle compare process.
module tb_bmux_2;

  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         s     = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic [W-1:0] r;
  logic [W-1:0] r_q;
  logic         s_q;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  bmux_2 #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .s    (s),
    .A    (A),
    .B    (B),
    .r    (r),
    .r_q  (r_q),
    .s_q  (s_q)
  );

  always #5 clk = ~clk;

  // Reference model: the operands are an indexed pair, the select picks one.
  function automatic logic [W-1:0] model_sel(logic sel, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] operand [2];
    operand[0] = a;
    operand[1] = b;
    return operand[sel];
  endfunction

  // Model of the pipeline copy: zero whenever reset is seen, otherwise the
  // value selected at the clock edge.
  logic [W-1:0] m_rq = '0;
  logic         m_sq = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rq = '0;
      m_sq = 1'b0;
    end else begin
      m_rq = model_sel(s, A, B);
      m_sq = s;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, 2 ns after each rising edge.
  always @(posedge clk) begin
    if (chk_en) begin
      #2;
      check("cyc_r",   r,   model_sel(s, A, B));
      check("cyc_r_q", r_q, m_rq);
      check("cyc_s_q", {15'd0, s_q}, {15'd0, m_sq});
    end
  end

  typedef struct {
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 16'h1357, 16'h2468};
    vecs[1] = '{1'b1, 16'h1357, 16'h2468};
    vecs[2] = '{1'b1, 16'hFFFF, 16'h8001};
    vecs[3] = '{1'b0, 16'h7FFE, 16'h0000};
    vecs[4] = '{1'b0, 16'hC3C3, 16'h3C3C};
    vecs[5] = '{1'b1, 16'hC3C3, 16'h3C3C};

    // Reset with no clock edge yet (first rising edge is at 5 ns).
    #1 reset = 1'b1;
    #1;
    check("rst_r_q", r_q, 16'h0000);
    check("rst_s_q", {15'd0, s_q}, 16'h0000);
    chk_en = 1'b1;

    // All-zero, while reset still held: r must stay functional.
    @(negedge clk);
    s = 1'b0; A = 16'h0000; B = 16'h0000;
    #1 check("zero_s0", r, 16'h0000);
    s = 1'b1;
    #1 check("zero_s1", r, 16'h0000);

    // Distinct inputs.
    @(negedge clk);
    A = 16'h0001; B = 16'h0002; s = 1'b0;
    #1 check("dist_s0", r, 16'h0001);
    s = 1'b1;
    #1 check("dist_s1", r, 16'h0002);

    // Wide complementary patterns, no leakage between inputs.
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0000; s = 1'b0;
    #1 check("wide_s0", r, 16'hFFFF);
    s = 1'b1;
    #1 check("wide_s1", r, 16'h0000);
    s = 1'b0;
    #1 check("wide_s0b", r, 16'hFFFF);

    // Input changes with select held at 1.
    @(negedge clk);
    s = 1'b1; B = 16'h1234;
    #1 check("hold_b1", r, 16'h1234);
    B = 16'hABCD;
    #1 check("hold_b2", r, 16'hABCD);
    A = 16'h5A5A;
    #1 check("hold_a", r, 16'hABCD);

    // Registers held at zero across an edge while reset is high.
    @(posedge clk);
    #1;
    check("rst_edge_r_q", r_q, 16'h0000);
    check("rst_edge_s_q", {15'd0, s_q}, 16'h0000);

    // Release reset, registered path.
    @(negedge clk);
    reset = 1'b0; A = 16'h00AA; B = 16'h0000; s = 1'b0;
    @(posedge clk);
    #1;
    check("reg1_r_q", r_q, 16'h00AA);
    check("reg1_s_q", {15'd0, s_q}, 16'h0000);
    @(negedge clk);
    s = 1'b1; B = 16'h5500;
    @(posedge clk);
    #1;
    check("reg2_r_q", r_q, 16'h5500);
    check("reg2_s_q", {15'd0, s_q}, 16'h0001);

    // Extra vectors, checked by the per-cycle compare.
    foreach (vecs[i]) begin
      @(negedge clk);
      s = vecs[i].sel; A = vecs[i].a; B = vecs[i].b;
    end
    @(posedge clk);
    #1;
    check("vec_last_r_q", r_q, 16'h3C3C);

    // Async reset between edges.
    @(negedge clk);
    s = 1'b1; A = 16'h0F0F; B = 16'hBEEF;
    @(posedge clk);
    #1 check("pre_rst_r_q", r_q, 16'hBEEF);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_r_q", r_q, 16'h0000);
    check("async_s_q", {15'd0, s_q}, 16'h0000);
    check("async_r", r, 16'hBEEF);
    @(negedge clk);
    reset = 1'b0; s = 1'b0;
    @(posedge clk);
    #1;
    check("resume_r_q", r_q, 16'h0F0F);
    check("resume_s_q", {15'd0, s_q}, 16'h0000);

    @(negedge clk);
    chk_en = 1'b0;
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bmux_2
